// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch types and constants
package fetch_queue_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;

  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  // Clear the byte-offset bits so an address names a whole instruction word.
  function automatic addr_t word_align(input addr_t a);
    return a & ~addr_t'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetch entries with registered head
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_next;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  head_q, head_d;

  // Next pointers and count; the head register keeps its last value once empty.
  always_comb begin
    rd_next = rd_q + 1'b1;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_next;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (pop) begin
        if (count_q > CW'(1)) head_d = mem_q[rd_next];
        else if (push)        head_d = push_data;
      end else if (count_q == '0 && push) begin
        head_d = push_data;
      end
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Entry storage; a flush discards any same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end feeding the decode stage
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int          CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_inst,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inc_pc,
  output logic [CW-1:0] occupancy
);

  addr_t        fetch_pc_q, fetch_pc_d;
  addr_t        req_pc_q, req_pc_d;
  logic         inflight_q, inflight_d;
  logic         seen_q;
  logic [CW-1:0] count;
  logic [CW:0]  used;
  logic         credit_ok, issue, push, pop;
  fetch_entry_t head, push_data;

  // A slot is reserved for the outstanding response; a same-cycle pop earns no credit.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = used < (CW + 1)'(DEPTH);
  assign issue     = !hold && !redirect && credit_ok;
  assign push      = inflight_q && !redirect;
  assign pop       = out_valid && out_ready && !redirect;
  assign push_data = '{pc: req_pc_q, inst: imem_data};

  // Next fetch address and the request tag that travels with the response.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + addr_t'(INST_BYTES);
      req_pc_d   = fetch_pc_q;
    end
  end

  // Fetch state; seen_q marks that the head register has held a real entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= word_align(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      seen_q     <= seen_q | out_valid;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  // Request is forced low while reset is held so nothing is fetched early.
  assign imem_req   = issue && rst;
  assign imem_addr  = fetch_pc_q;
  assign out_valid  = (count != '0);
  assign out_inst   = head.inst;
  assign out_pc     = head.pc;
  assign out_inc_pc = (seen_q || out_valid) ? head.pc + addr_t'(INST_BYTES) : '0;
  assign occupancy  = count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end placed directly upstream of the ID stage. Generates sequential word addresses to the synchronous instruction memory, buffers returned instructions with their PC in a small FIFO, and presents them to decode under a valid/ready handshake. Branch and jump redirects from ID flush the queue and restart fetch at the target, which replaces the bare PC register and prefetch-flush path in front of decode.

## Interface

- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- hold  input  1  suspends new fetch requests (program-load mode).
- redirect  input  1  ID branch/jump taken this cycle.
- redirect_pc  input  32  target byte address; bits [1:0] ignored.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  32  word-aligned request address; bits [1:0] always 0.
- imem_data  input  32  instruction for the request issued in the previous cycle.
- out_valid  output  1  head entry is available to ID.
- out_ready  input  1  ID accepts head (not stalled).
- out_inst  output  32  head instruction.
- out_pc  output  32  head PC.
- out_inc_pc  output  32  out_pc + 4, modulo 2^32.
- occupancy  output  $clog2(DEPTH+1)  current entry count.

## Operation

- State: fetch_pc, inflight bit, FIFO storage, rd/wr pointers, count.
- Reset values while rst=0: fetch_pc=RESET_PC, inflight=0, count=0, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, out_inc_pc=0, occupancy=0.
- Issue: imem_req = !hold && !redirect && (count + inflight < DEPTH). imem_addr = fetch_pc. On issue: fetch_pc += 4 and inflight <= 1. With no issue: inflight <= 0.
- Capture: if inflight=1 and no redirect this cycle, push {pc_of_request, imem_data}. The request PC is held in a register alongside inflight.
- Pop: out_valid=1 iff count>0. On out_valid && out_ready && !redirect, the head is removed.
- Push and pop in the same cycle leave count unchanged. The credit check ignores a same-cycle pop, so there is no full-bypass path.
- Redirect wins over everything:
  - count <= 0, pointers reset.
  - The current inflight response is discarded.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No request is issued in the redirect cycle.
  - A head accepted by ID in the same cycle is also dropped.
- hold does not cancel an inflight response. It only blocks new issues. redirect during hold still flushes and reloads fetch_pc.
- Outputs out_* come from the FIFO head registers. When count=0 they hold their last value; only out_valid is meaningful.

## Timing

- Request in cycle t gives data on imem_data in t+1, pushed at the t+1 edge, and out_valid in t+2. Best-case fetch-to-decode latency is 2 cycles.
- Redirect at t: request to target at t+1, out_valid with the target instruction at t+3.
- After rst rises: first request in the first cycle, first out_valid two cycles later.
- Steady state with out_ready=1: one instruction per cycle. count stays at 1 and inflight at 1.
- out_ready low: the queue fills to DEPTH and imem_req drops. Issue resumes in the cycle after a pop makes count + inflight < DEPTH.
- Pointer wrap: modulo DEPTH, no gap in the sequence. fetch_pc wraps from 32'hFFFF_FFFC to 0.
- rst asserted mid-operation: all state clears immediately. The in-flight response is never pushed.

## Structure

- Shared package FetchType:
  - fetch_entry_t struct {addr_t pc; inst_t inst}.
  - Constant INST_BYTES=4.
  - Reuse addr_t/inst_t from Types.
- Sub-module fetch_fifo: parameterised circular buffer of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - Async active-low rst.
- fetch_queue holds fetch_pc, inflight, the request-PC register and the issue/credit logic.

## Test plan

- Reset, then run with out_ready=1 and memory word[i]=i: out_pc sequence 0,4,8,... with out_inst 0,1,2,...; first out_valid 2 cycles after reset release; one entry per cycle.
- out_ready=0 for 10 cycles: occupancy reaches 4 and imem_req=0. Release: entries drain in order and issue resumes.
- Redirect to 32'h0000_0103 while 3 entries are queued and 1 is inflight: occupancy=0 next cycle, imem_addr=32'h100 one cycle after redirect, first out_pc=32'h100 three cycles after redirect, no stale instruction delivered.
- Redirect with out_ready=1 on a valid head: the head is not delivered again and the target is fetched. hold=1 with one inflight: that entry is still pushed and no further imem_req occurs.
- Start RESET_PC=32'hFFFF_FFF8: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; out_inc_pc of the last is 4.
- Assert rst with 2 queued entries and 1 inflight: all outputs take reset values immediately. Restart delivers RESET_PC first.
